// File: rtl/ifu_fetch.sv
// Instruction fetch stage: holds the PC, reads imem with req/ack and presents the word to decode.
// Latency: ack in cycle M gives Fetch_ready in M+1; minimum fetch is 2 cycles from REQ entry.
// Backpressure: waits on imem_ack (timeout fault after TIMEOUT_CYCLES); holds the word until pc_update.
// Optional: define IFU_PERF_CNT_EN to add fetch_count/stall_count outputs.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        soc_clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic        Fetch_ready,
  output logic [31:0] pc,
  input  logic        pc_update,
  input  logic [31:0] pc_increment,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        fetch_fault,
  output logic [1:0]  fault_cause
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count
`endif
);

  typedef enum logic [1:0] {
    ST_RST   = 2'd0,
    ST_REQ   = 2'd1,
    ST_HOLD  = 2'd2,
    ST_FAULT = 2'd3
  } state_t;

  localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT_CYCLES);

  state_t      r_state;
  state_t      w_state_next;
  logic [7:0]  r_tmo_cnt;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [1:0]  r_cause;
  logic [31:0] w_next_pc;
  logic        w_ack_take;
  logic        w_timeout;
  logic        w_advance;
  logic        w_misalign;
  logic        w_unused_tgt_lsb;

  // Branch targets are forced to halfword alignment, so bit 0 never matters.
  assign w_unused_tgt_lsb = branch_target[0];

  // Candidate next PC: branch path wins over sequential/JAL offset; add wraps mod 2^32.
  always_comb begin
    w_next_pc = r_pc + pc_increment;
    if (branch_taken) begin
      w_next_pc = {branch_target[31:1], 1'b0};
    end
  end

  // Next-state and output decode.
  always_comb begin
    w_state_next = r_state;
    w_ack_take   = 1'b0;
    w_timeout    = 1'b0;
    w_advance    = 1'b0;
    w_misalign   = 1'b0;
    imem_req     = 1'b0;
    Fetch_ready  = 1'b0;
    fetch_fault  = 1'b0;
    case (r_state)
      ST_RST: begin
        w_state_next = ST_REQ;
      end
      ST_REQ: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          w_ack_take   = 1'b1;
          w_state_next = ST_HOLD;
        end else if ((r_tmo_cnt + 8'd1) == TMO_LIMIT) begin
          w_timeout    = 1'b1;
          w_state_next = ST_FAULT;
        end
      end
      ST_HOLD: begin
        Fetch_ready = 1'b1;
        // Only samples taken while already in HOLD count; the HOLD-entry edge is sampled in REQ.
        if (pc_update) begin
          if (w_next_pc[1]) begin
            w_misalign   = 1'b1;
            w_state_next = ST_FAULT;
          end else begin
            w_advance    = 1'b1;
            w_state_next = ST_REQ;
          end
        end
      end
      ST_FAULT: begin
        fetch_fault = 1'b1;
      end
      default: begin
        w_state_next = ST_RST;
      end
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge soc_clk) begin
    if (!reset) begin
      r_state <= ST_RST;
    end else begin
      r_state <= w_state_next;
    end
  end

  // PC, latched instruction, timeout counter and fault cause.
  always_ff @(posedge soc_clk) begin
    if (!reset) begin
      r_pc      <= RESET_PC;
      r_instr   <= 32'h0000_0000;
      r_cause   <= 2'b00;
      r_tmo_cnt <= 8'd0;
    end else begin
      if (r_state == ST_REQ) begin
        r_tmo_cnt <= w_ack_take ? 8'd0 : (r_tmo_cnt + 8'd1);
      end
      if (w_ack_take) begin
        r_instr <= imem_rdata;
      end
      if (w_advance) begin
        r_pc <= w_next_pc;
      end
      if (w_timeout) begin
        r_cause <= 2'b10;
      end
      if (w_misalign) begin
        r_cause <= 2'b01;
      end
    end
  end

  assign imem_addr   = r_pc;
  assign pc          = r_pc;
  assign instruction = r_instr;
  assign fault_cause = r_cause;

`ifdef IFU_PERF_CNT_EN
  logic [31:0] r_fetch_cnt;
  logic [31:0] r_stall_cnt;

  // Performance counters only move in REQ, so they naturally freeze in FAULT.
  always_ff @(posedge soc_clk) begin
    if (!reset) begin
      r_fetch_cnt <= 32'd0;
      r_stall_cnt <= 32'd0;
    end else if (r_state == ST_REQ) begin
      if (imem_ack) begin
        r_fetch_cnt <= r_fetch_cnt + 32'd1;
      end else begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
    end
  end

  assign fetch_count = r_fetch_cnt;
  assign stall_count = r_stall_cnt;
`endif

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
- Instruction fetch stage directly upstream of the decode stage.
- Holds the architectural PC, issues a request/acknowledge read to instruction memory, latches the returned word and presents it as `instruction` with `Fetch_ready`.
- Advances the PC when the control unit retires the current instruction, using either the decoder's `pc_increment` or a taken-branch target.
- Detects misaligned targets and memory timeouts.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- TIMEOUT_CYCLES, 16, cycles `imem_req` may stay high without `imem_ack` before a fault is raised (legal range 2..255).

Ports:
- soc_clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- imem_req  out  1  read request to instruction memory.
- imem_addr  out  32  word address of the read; equals `pc` while `imem_req` is high.
- imem_ack  in  1  memory acknowledge; `imem_rdata` is valid in the same cycle.
- imem_rdata  in  32  instruction word from memory.
- instruction  out  32  latched instruction to the decoder.
- Fetch_ready  out  1  `instruction` is valid and stable.
- pc  out  32  PC of the instruction currently presented.
- pc_update  in  1  one-cycle strobe from the CU: current instruction retired, advance the PC.
- pc_increment  in  32  signed PC offset from the decoder (4, or the JAL offset).
- branch_taken  in  1  qualifies `pc_update`: use `branch_target` instead of `pc + pc_increment`.
- branch_target  in  32  absolute next PC from the CU (branches, JALR).
- fetch_fault  out  1  sticky fault flag.
- fault_cause  out  2  2'b00 none, 2'b01 misaligned target, 2'b10 memory timeout.

Behaviour:
- Reset (`reset` = 0 at a rising edge):
  - `pc` = RESET_PC, state RST, `imem_req` = 0, `imem_addr` = RESET_PC.
  - `instruction` = 32'h0000_0000, `Fetch_ready` = 0, `fetch_fault` = 0, `fault_cause` = 0, timeout counter = 0.
  - Reset asserted in any state aborts the operation; `imem_req` is low in the cycle after the reset edge, and any late `imem_ack` is ignored.
- State RST: first cycle with `reset` = 1 → REQ.
- State REQ:
  - `imem_req` = 1, `imem_addr` = `pc`, timeout counter increments every cycle.
  - `imem_ack` = 1 sampled: `instruction` <= `imem_rdata`, counter cleared, → HOLD.
  - Counter reaches TIMEOUT_CYCLES with no ack: → FAULT, cause 2'b10.
  - `imem_req` drops the cycle after the ack.
- State HOLD:
  - `Fetch_ready` = 1; `instruction` and `pc` are stable.
  - Latency: ack in cycle M → `Fetch_ready` high in M+1. A same-cycle ack gives a minimum fetch of 2 cycles from REQ entry.
  - `pc_update` = 1 computes the next PC:
    - If `branch_taken` = 1: next = {branch_target[31:1], 1'b0}.
    - Otherwise: next = `pc` + `pc_increment`, 32-bit modulo (wraps through 0, no overflow flag).
  - If next[1] = 1: → FAULT, cause 2'b01, `pc` unchanged.
  - Otherwise: `pc` <= next, `Fetch_ready` low in the next cycle, → REQ.
  - `Fetch_ready` is low for at least one cycle between consecutive instructions, so the decoder always sees a falling edge.
- State FAULT:
  - `fetch_fault` = 1, `Fetch_ready` = 0, `imem_req` = 0. Only reset exits.
- `pc_update` outside HOLD is ignored (no PC change, no error).
- `branch_taken` without `pc_update` has no effect; `pc_update` with `branch_taken` uses the branch path (branch wins).
- `pc_update` coinciding with the `Fetch_ready` rising cycle (HOLD entry) is ignored; only HOLD-state samples count.

Optional Feature:
- IFU_PERF_CNT_EN defined adds two outputs:
  - `fetch_count[31:0]`: increments on every accepted `imem_ack`.
  - `stall_count[31:0]`: increments on every REQ cycle with `imem_ack` = 0.
  - Both counters reset to 0, wrap modulo 2^32, and freeze in FAULT.
- IFU_PERF_CNT_EN undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset release with memory acking the same cycle, `imem_rdata` = 32'h0050_0093 → `imem_addr` = 0; `instruction` = 32'h0050_0093 and `Fetch_ready` = 1 two cycles after release; `pc` = 0.
- HOLD, `pc_update` = 1, `pc_increment` = 4 → `Fetch_ready` low the next cycle; `imem_addr` = 4; after ack `pc` = 4.
- `pc` = 32'h0000_0100, `pc_update` with `branch_taken` = 1, `branch_target` = 32'h0000_0205 → next `pc` = 32'h0000_0204, fetch issued at 0x204.
- `pc` = 32'hFFFF_FFFC, `pc_increment` = 8 → `pc` wraps to 32'h0000_0004; `pc_increment` = 6 from `pc` = 0 → `fetch_fault` = 1, `fault_cause` = 2'b01, `imem_req` stays 0.
- `imem_ack` held low with TIMEOUT_CYCLES = 16 → after 16 REQ cycles `fetch_fault` = 1, `fault_cause` = 2'b10; a later ack is ignored; `reset` low → all outputs return to their reset values.
- `reset` driven low during a REQ wait → `imem_req` = 0 in the next cycle and `pc` = RESET_PC; with IFU_PERF_CNT_EN defined, 3 fetches each with 2 wait cycles → `fetch_count` = 3, `stall_count` = 6.
